// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory request port.
package mem_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 16;

  // One load response as it travels through the response FIFO.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } mem_rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous in-order FIFO of load responses; the head entry is read straight from its
// storage register.
module resp_fifo
  import mem_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  mem_rsp_t                     wdata,
  input  logic                         pop,
  output mem_rsp_t                     rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  mem_rsp_t            mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // Push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port.sv
// Requester-side front end for a synchronous-read RAM. Accepts one load/store per cycle and
// returns load data in order through resp_fifo.
// Optional feature: define MEM_BOUNDS_EN to flag out-of-range addresses (dropped stores,
// error responses for loads); otherwise upper address bits are ignored and rspErr stays 0.
module mem_port
  import mem_pkg::*;
#(
  parameter int unsigned DataWidth  = DATA_WIDTH,
  parameter int unsigned NumWords   = 8,
  parameter int unsigned IndexWidth = $clog2(NumWords),
  parameter int unsigned AddrWidth  = ADDR_WIDTH,
  parameter int unsigned RespDepth  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [AddrWidth-1:0]  reqAddr,
  input  logic [DataWidth-1:0]  reqWData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DataWidth-1:0]  rspRData,
  output logic                  rspErr,
  output logic                  ramWriteEnable,
  output logic [IndexWidth-1:0] ramWriteAddr,
  output logic [DataWidth-1:0]  ramWriteData,
  output logic [IndexWidth-1:0] ramReadAddr,
  input  logic [DataWidth-1:0]  ramReadData
);

  localparam int unsigned OutW = $clog2(RespDepth + 1);

  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic            pend_q, pend_err_q;
  logic            addr_ok, req_acc, load_acc, store_acc;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [OutW-1:0] fifo_count;
  mem_rsp_t        push_rsp, head_rsp;
  logic            unused_fifo;

`ifdef MEM_BOUNDS_EN
  assign addr_ok = (reqAddr < AddrWidth'(NumWords));
`else
  // Upper address bits alias onto the RAM index.
  logic unused_addr_hi;
  assign addr_ok        = 1'b1;
  assign unused_addr_hi = ^reqAddr[AddrWidth-1:IndexWidth];
`endif

  // A slot is reserved per outstanding load, so the FIFO can never overflow.
  assign reqReady  = !rst && (outstanding_q < OutW'(RespDepth));
  assign req_acc   = reqValid && reqReady;
  assign store_acc = req_acc && reqWrite;
  assign load_acc  = req_acc && !reqWrite;

  assign ramWriteEnable = store_acc && addr_ok;
  assign ramWriteAddr   = reqAddr[IndexWidth-1:0];
  assign ramWriteData   = reqWData;
  assign ramReadAddr    = reqAddr[IndexWidth-1:0];

  // Pending-load flag: RAM data for this load arrives in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q     <= load_acc;
      pend_err_q <= load_acc && !addr_ok;
    end
  end

  // Build the response from RAM data; out-of-range loads return zero data.
  always_comb begin
    push_rsp      = '0;
    push_rsp.err  = pend_err_q;
    push_rsp.data = pend_err_q ? '0 : DATA_WIDTH'(ramReadData);
  end

  resp_fifo #(
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .wdata (push_rsp),
    .pop   (fifo_pop),
    .rdata (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_fifo = fifo_full ^ (^fifo_count);

  assign rspValid = !fifo_empty && !rst;
  assign fifo_pop = rspValid && rspReady;
  assign rspRData = DataWidth'(head_rsp.data);
  assign rspErr   = head_rsp.err;

  // Outstanding loads: +1 on load accept, -1 on response pop.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({load_acc, fifo_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: a synchronous-read RAM plus a queue-based reference model of the
// request/response contract, driven by directed sequences and random traffic.
module tb_mem_port;

  localparam int unsigned NumWords = 8;
  localparam int unsigned Depth    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWrite;
  logic [15:0] reqAddr, reqWData;
  logic        rspValid, rspReady, rspErr;
  logic [15:0] rspRData;
  logic        ramWriteEnable;
  logic [2:0]  ramWriteAddr, ramReadAddr;
  logic [15:0] ramWriteData, ramReadData;

  always #5 clk = ~clk;

  mem_port #(
    .DataWidth  (16),
    .NumWords   (NumWords),
    .IndexWidth (3),
    .AddrWidth  (16),
    .RespDepth  (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqAddr        (reqAddr),
    .reqWData       (reqWData),
    .rspValid       (rspValid),
    .rspReady       (rspReady),
    .rspRData       (rspRData),
    .rspErr         (rspErr),
    .ramWriteEnable (ramWriteEnable),
    .ramWriteAddr   (ramWriteAddr),
    .ramWriteData   (ramWriteData),
    .ramReadAddr    (ramReadAddr),
    .ramReadData    (ramReadData)
  );

  // Synchronous-read RAM.
  logic [15:0] ram [NumWords];
  always @(posedge clk) begin
    if (ramWriteEnable) ram[ramWriteAddr] <= ramWriteData;
    ramReadData <= ram[ramReadAddr];
  end

  // Reference model: expected responses with the cycle they become visible.
  typedef struct {
    logic [15:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mdl_mem [NumWords];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          last_acc;
  bit          prev_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit addr_ok(input logic [15:0] a);
`ifdef MEM_BOUNDS_EN
    return a < 16'(NumWords);
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: drive inputs, check DUT against the model, then advance the model.
  task automatic step(input logic v, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic rr, input logic r);
    bit   exp_ready, exp_valid, exp_we, ok;
    exp_t e;
    @(negedge clk);
    rst = r; reqValid = v; reqWrite = w; reqAddr = a; reqWData = d; rspReady = rr;
    #1;
    ok        = addr_ok(a);
    exp_ready = !r && (q.size() < Depth);
    exp_valid = !r && (q.size() > 0) && (q[0].due <= cyc);
    exp_we    = v && exp_ready && w && ok;
    check("reqReady", {31'b0, reqReady}, {31'b0, exp_ready});
    check("rspValid", {31'b0, rspValid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("rspRData", {16'b0, rspRData}, {16'b0, q[0].data});
      check("rspErr", {31'b0, rspErr}, {31'b0, q[0].err});
    end
    if (prev_rst && !r) begin
      check("rspRData_after_rst", {16'b0, rspRData}, 32'h0);
      check("rspErr_after_rst", {31'b0, rspErr}, 32'h0);
    end
    check("ramWriteEnable", {31'b0, ramWriteEnable}, {31'b0, exp_we});
    if (exp_we) begin
      check("ramWriteAddr", {29'b0, ramWriteAddr}, {29'b0, a[2:0]});
      check("ramWriteData", {16'b0, ramWriteData}, {16'b0, d});
    end
    check("ramReadAddr", {29'b0, ramReadAddr}, {29'b0, a[2:0]});
    last_acc = v && exp_ready;
    if (r) begin
      q.delete();
    end else begin
      if (exp_valid && rr) void'(q.pop_front());
      if (v && exp_ready) begin
        if (w) begin
          if (ok) mdl_mem[a[2:0]] = d;
        end else begin
          e.data = ok ? mdl_mem[a[2:0]] : 16'h0;
          e.err  = !ok;
          e.due  = cyc + 2;
          q.push_back(e);
        end
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  // Offer one request until accepted, bounded.
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic rr);
    int tries = 0;
    last_acc = 1'b0;
    while (!last_acc && tries < 20) begin
      step(1'b1, w, a, d, rr, 1'b0);
      tries++;
    end
    check("send_accept", {31'b0, last_acc}, 32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int unsigned nxt;
    logic [15:0] ra;
    for (int i = 0; i < int'(NumWords); i++) begin
      ram[i]     = 16'h0;
      mdl_mem[i] = 16'h0;
    end
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWData = '0;
    rspReady = 1'b0;

    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    idle(2);

    // Store then immediate load of the same word.
    send(1'b1, 16'd3, 16'h1234, 1'b1);
    send(1'b0, 16'd3, 16'h0, 1'b1);
    idle(4);

    // Fill all words, then stream loads.
    for (int i = 0; i < 8; i++) send(1'b1, 16'(i), 16'h00A0 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) send(1'b0, 16'(i), 16'h0, 1'b1);
    idle(4);

    // Backpressure: loads offered while responses are held, then a single pop.
    nxt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 16'(nxt), 16'h0, 1'b0, 1'b0);
      if (last_acc) nxt++;
    end
    step(1'b1, 1'b0, 16'(nxt), 16'h0, 1'b1, 1'b0);
    if (last_acc) nxt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'(nxt), 16'h0, 1'b0, 1'b0);
      if (last_acc) nxt++;
    end
    idle(6);

    // Reset with loads in flight: nothing may come out afterwards.
    send(1'b0, 16'd1, 16'h0, 1'b0);
    send(1'b0, 16'd2, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    idle(6);

    // Out-of-range store and load, then a load of word 0.
    send(1'b1, 16'd8, 16'hBEEF, 1'b1);
    send(1'b0, 16'd8, 16'h0, 1'b1);
    send(1'b0, 16'd0, 16'h0, 1'b1);
    idle(5);

    // Continuous load stream with random response backpressure.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 16'($urandom_range(0, 9)), 16'h0, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(5);

    // Fully random traffic including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), ra,
           16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    idle(8);

    for (int i = 0; i < int'(NumWords); i++) begin
      check($sformatf("ram[%0d]", i), {16'b0, ram[i]}, {16'b0, mdl_mem[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
